bcd_conv_ctrl: RTL and testbench
================================

# bcd_conv_ctrl

Sequential binary-to-BCD conversion controller with a display digit scanner for the 8-bit counter datapath. It converts the counter value with an iterative double-dabble, one bit per clock, under a start/busy/done handshake, and holds the last result. It then time-multiplexes the three BCD digits onto a shared 7-segment digit bus, with leading-zero blanking.

## Interface
- `SCAN_DIV`, 50000: clock cycles each digit stays selected; legal range ≥2.
- `BLANK_EN`, 1: 1 enables leading-zero blanking on `dig_val`; 0 disables it.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bin_in` in 8: binary value; sampled only on the edge that accepts `start`.
- `start` in 1: conversion request; level-sampled.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse; `bcd_out` was updated on the same edge.
- `bcd_out` out 12: registered result {hundreds, tens, ones}.
- `dig_sel` out 3: one-hot digit enable, active high; bit0 = ones, bit1 = tens, bit2 = hundreds.
- `dig_val` out 4: BCD nibble for the selected digit; 4'hF means blank.

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- **IDLE**
  - If `start`=1: load `shreg`←`bin_in`, `work`←12'h000, `cnt`←0; go to SHIFT.
  - `busy`=0 while in IDLE.
- **SHIFT** (8 iterations, one per edge, MSB first):
  - Add 3 to each nibble of `work` that is ≥5.
  - Shift `work` left one bit; the new LSB is `shreg[7]`.
  - Shift `shreg` left one bit.
  - Increment `cnt`.
  - After the iteration with `cnt`=7, go to FINISH.
- **FINISH**
  - `bcd_out`←`work`, `done`←1 for one cycle.
  - Go to IDLE.
- `start` is ignored in SHIFT and FINISH; there is no queueing.
- Arithmetic:
  - `work` is 12 bits; each nibble is adjusted independently.
  - The hundreds nibble never exceeds 2, so no overflow is possible for 8-bit input.
  - `cnt` is 3 bits.
- `bcd_out` holds its value until the next FINISH.
- Scanner (runs regardless of FSM state):
  - `div` counts 0..`SCAN_DIV`-1, then wraps to 0.
  - When `div` wraps, `idx` advances 0→1→2→0.
  - `dig_sel` = 1<<`idx`.
  - `dig_val` = nibble `idx` of `bcd_out`, combinational from registered `idx` and `bcd_out`.
- Blanking (`BLANK_EN`=1):
  - Hundreds is blanked when it is 0.
  - Tens is blanked when hundreds and tens are both 0.
  - Ones is never blanked.
  - A blanked digit outputs 4'hF.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd_out`=12'h000, `div`=0, `idx`=0, `dig_sel`=3'b001.
- `dig_val` out of reset is 4'h0, since ones is never blanked.
- `start` accepted at edge k:
  - `busy`=1 from edge k through edge k+9.
  - Shifts occur at edges k+1 through k+8.
  - At edge k+9: `bcd_out` updates, `done`=1 and `busy`=0 together.
- Latency from accepting edge to `done` is 9 cycles. Minimum request period is 10 cycles.
- A `start` held high while `done`=1 (state IDLE) is accepted on the following edge. Back-to-back conversions therefore repeat every 10 cycles.
- Reset mid-conversion: all registers return to reset values immediately. The partial result is discarded, `bcd_out` reads 0, and no `done` is produced.
- The scanner is independent of the handshake. A `bcd_out` update is visible on `dig_val` in the same cycle it registers.

## Structure
- Package `bcd_pkg`:
  - State encoding: IDLE, SHIFT, FINISH.
  - `BCD_DIGITS`=3, `BIN_W`=8, `BLANK_CODE`=4'hF.
- Sub-module `bcd_dd_step` (combinational): 12-bit `work` plus incoming bit in, adjusted-and-shifted 12-bit value out. It is instantiated once in the SHIFT datapath.
- The scanner (`div`, `idx`, blanking mux) stays inline in `bcd_conv_ctrl`.

## Test plan
1. `bin_in`=8'd255, single `start` pulse → `busy` high 9 cycles; `done` at edge +9; `bcd_out`=12'h255.
2. `bin_in`=0, `start` pulse → `bcd_out`=12'h000. With `SCAN_DIV`=4, `dig_sel` cycles 001,010,100 every 4 clocks and `dig_val` reads 0,F,F.
3. `start` held high continuously, `bin_in` stepping 0..255 → one `done` every 10 cycles; every `bcd_out` matches the decimal reference.
4. `bin_in`=8'd9 accepted, then `bin_in`=8'd200 with `start` on cycles +3 and +8 → both requests ignored; `bcd_out`=12'h009; `dig_val` shows 9,F,F.
5. `bin_in`=8'd137 accepted, `rst_n` low at cycle +5 → immediately `busy`=0, `bcd_out`=0, `dig_sel`=001, `idx`=0; no `done` until a new `start`.
6. `BLANK_EN`=0, `bin_in`=8'd5 → `dig_val` sequence 5,0,0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types, constants and the double-dabble nibble adjust for the BCD conversion controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int         BCD_DIGITS = 3;
    localparam int         BIN_W      = 8;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // A nibble of 5 or more becomes 10 or more after the shift, so it is pre-corrected by 3.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: adjust each BCD nibble, then shift in the next binary bit.
module bcd_dd_step
    import bcd_pkg::*;
(
    input  logic [4*BCD_DIGITS-1:0] work,
    input  logic                    bit_in,
    output logic [4*BCD_DIGITS-1:0] work_next
);

    logic [4*BCD_DIGITS-1:0] adj_s;

    // Adjust all nibbles independently; the dropped top bit is always zero for 8-bit input.
    always_comb begin
        adj_s     = {dd_adjust(work[11:8]), dd_adjust(work[7:4]), dd_adjust(work[3:0])};
        work_next = {adj_s[10:0], bit_in};
    end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Iterative binary-to-BCD converter with start/busy/done handshake and a
// multiplexed three-digit display scanner with optional leading-zero blanking.
module bcd_conv_ctrl
    import bcd_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic [2:0]              dig_sel,
    output logic [3:0]              dig_val
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_t                  state_r;
    logic [BIN_W-1:0]        shreg_r;
    logic [4*BCD_DIGITS-1:0] work_r;
    logic [4*BCD_DIGITS-1:0] work_next_s;
    logic [2:0]              cnt_r;
    logic                    busy_r;
    logic                    done_r;
    logic [4*BCD_DIGITS-1:0] bcd_out_r;

    logic [DIV_W-1:0]        div_r;
    logic [1:0]              idx_r;
    logic [2:0]              dig_sel_r;
    logic [3:0]              dig_val_s;
    logic                    blank_hund_s;
    logic                    blank_tens_s;

    bcd_dd_step u_step (
        .work      (work_r),
        .bit_in    (shreg_r[BIN_W-1]),
        .work_next (work_next_s)
    );

    // Conversion FSM: load on start, eight MSB-first shifts, then publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            shreg_r   <= 8'h00;
            work_r    <= 12'h000;
            cnt_r     <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bcd_out_r <= 12'h000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        shreg_r <= bin_in;
                        work_r  <= 12'h000;
                        cnt_r   <= 3'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    done_r  <= 1'b0;
                    work_r  <= work_next_s;
                    shreg_r <= {shreg_r[BIN_W-2:0], 1'b0};
                    cnt_r   <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        state_r <= ST_FINISH;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_FINISH: begin
                    bcd_out_r <= work_r;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Digit scanner: dwell SCAN_DIV cycles per digit, rotating ones -> tens -> hundreds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r     <= '0;
            idx_r     <= 2'd0;
            dig_sel_r <= 3'b001;
        end else if (div_r == DIV_LAST) begin
            div_r <= '0;
            if (idx_r == 2'd2) begin
                idx_r     <= 2'd0;
                dig_sel_r <= 3'b001;
            end else begin
                idx_r     <= idx_r + 2'd1;
                dig_sel_r <= {dig_sel_r[1:0], 1'b0};
            end
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Digit value mux with leading-zero blanking; follows bcd_out in the cycle it updates.
    always_comb begin
        blank_hund_s = BLANK_EN && (bcd_out_r[11:8] == 4'd0);
        blank_tens_s = blank_hund_s && (bcd_out_r[7:4] == 4'd0);
        case (idx_r)
            2'd0:    dig_val_s = bcd_out_r[3:0];
            2'd1:    dig_val_s = blank_tens_s ? BLANK_CODE : bcd_out_r[7:4];
            2'd2:    dig_val_s = blank_hund_s ? BLANK_CODE : bcd_out_r[11:8];
            default: dig_val_s = BLANK_CODE;
        endcase
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bcd_out = bcd_out_r;
    assign dig_sel = dig_sel_r;
    assign dig_val = dig_val_s;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Scoreboard bench for bcd_conv_ctrl: a blanking and a non-blanking instance share stimulus.
module tb_bcd_conv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  bin_in;
    logic        start;
    logic        busy, done, busy_nb, done_nb;
    logic [11:0] bcd_out, bcd_out_nb;
    logic [2:0]  dig_sel, dig_sel_nb;
    logic [3:0]  dig_val, dig_val_nb;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [11:0] exp_q[$];

    bcd_conv_ctrl #(.SCAN_DIV(4), .BLANK_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .start(start),
        .busy(busy), .done(done), .bcd_out(bcd_out),
        .dig_sel(dig_sel), .dig_val(dig_val)
    );

    bcd_conv_ctrl #(.SCAN_DIV(4), .BLANK_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .start(start),
        .busy(busy_nb), .done(done_nb), .bcd_out(bcd_out_nb),
        .dig_sel(dig_sel_nb), .dig_val(dig_val_nb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got bcd_out 0x%0h, expected no done (cycle %0d)", bcd_out, cyc);
            end else begin
                chk("bcd_out", int'(bcd_out), int'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] v, input logic [11:0] e);
        bin_in = v;
        start  = 1'b1;
        exp_q.push_back(e);
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < budget);
        chk("done_timeout", int'(done), 1);
    endtask

    task automatic scan_check(input int e0, input int e1, input int e2,
                              input int n0, input int n1, input int n2);
        int n = 0;
        int ev[3];
        int nv[3];
        ev = '{e0, e1, e2};
        nv = '{n0, n1, n2};
        while (dig_sel !== 3'b100 && n < 20) begin tick(); n++; end
        while (dig_sel !== 3'b001 && n < 40) begin tick(); n++; end
        chk("scan_sync", int'(dig_sel), 1);
        for (int j = 0; j < 12; j++) begin
            chk("dig_sel", int'(dig_sel), 1 << (j / 4));
            chk("dig_val", int'(dig_val), ev[j / 4]);
            chk("dig_val_noblank", int'(dig_val_nb), nv[j / 4]);
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last;
        int dcount;
        rst_n  = 1'b0;
        bin_in = 8'h00;
        start  = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bcd_out", int'(bcd_out), 0);
        chk("rst_dig_sel", int'(dig_sel), 1);
        chk("rst_dig_val", int'(dig_val), 0);
        rst_n = 1'b1;
        tick();

        // 255: busy for nine cycles, done at edge +9, single-cycle pulse
        issue(8'd255, 12'h255);
        for (int i = 0; i < 9; i++) begin
            chk("busy_high", int'(busy), 1);
            chk("done_early", int'(done), 0);
            tick();
        end
        chk("done_at_9", int'(done), 1);
        chk("busy_low_at_9", int'(busy), 0);
        tick();
        chk("done_pulse", int'(done), 0);

        // zero: all leading digits blanked
        issue(8'd0, 12'h000);
        wait_done(12);
        scan_check(0, 15, 15, 0, 0, 0);

        // 9 accepted; starts during conversion must be ignored
        issue(8'd9, 12'h009);
        bin_in = 8'd200;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(5);
        repeat (12) tick();
        chk("ignored_start_busy", int'(busy), 0);
        chk("ignored_start_queue", exp_q.size(), 0);
        chk("ignored_start_bcd", int'(bcd_out), 12'h009);
        scan_check(9, 15, 15, 9, 0, 0);

        // reset in the middle of converting 137
        issue(8'd137, 12'h137);
        repeat (5) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_bcd_out", int'(bcd_out), 0);
        chk("midrst_dig_sel", int'(dig_sel), 1);
        chk("midrst_dig_val", int'(dig_val), 0);
        tick(); tick();
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        chk("midrst_no_done", dcount, 0);
        chk("midrst_bcd_hold", int'(bcd_out), 0);

        // 5: blanked 5,F,F versus unblanked 5,0,0
        issue(8'd5, 12'h005);
        wait_done(12);
        chk("noblank_bcd_out", int'(bcd_out_nb), 12'h005);
        scan_check(5, 15, 15, 5, 0, 0);

        // start held high, sweep 0..255, one result every 10 cycles
        last   = 0;
        bin_in = 8'd0;
        start  = 1'b1;
        exp_q.push_back(ref_bcd(0));
        for (int v = 0; v < 256; v++) begin
            wait_done(20);
            if (v > 0) chk("period", cyc - last, 10);
            last = cyc;
            if (v < 255) begin
                bin_in = 8'(v + 1);
                exp_q.push_back(ref_bcd(v + 1));
            end else begin
                start = 1'b0;
            end
        end
        repeat (12) tick();
        chk("sweep_queue_empty", exp_q.size(), 0);
        chk("sweep_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
